// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, I2S timebase bit positions, stereo frame type.
package audio_pkg;

  localparam int unsigned AUDIO_DW = 24;

  // 10-bit timebase: MCLK = clk/2, SCLK = clk/16, LRCK = clk/1024
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned MCLK_BIT = 0;
  localparam int unsigned SCLK_BIT = 3;
  localparam int unsigned LRCK_BIT = 9;

  // One SCLK period per bit slot, 32 slots per channel
  localparam int unsigned SLOT_LSB = 4;
  localparam int unsigned SLOT_W   = 5;
  localparam int unsigned SLOT_CNT = 32;

  typedef struct packed {
    logic [AUDIO_DW-1:0] left;
    logic [AUDIO_DW-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a pop on the same cycle frees room for a push into a full FIFO.
module sync_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_d;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level_d = level - LVL_W'(do_pop) + LVL_W'(do_push);

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered not-full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      ready <= (level_d != LVL_W'(DEPTH));
    end
  end

endmodule

// File: rtl/axis_i2s_tx.sv
// AXIS audio to Philips I2S serialiser: pairs L/R beats into frames, buffers them, drives MCLK/SCLK/LRCK/SDOUT.
module axis_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DW,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       s_axis_data,
  input  logic                        s_axis_valid,
  output logic                        s_axis_ready,
  input  logic                        s_axis_last,
  output logic                        tx_mclk,
  output logic                        tx_sclk,
  output logic                        tx_lrck,
  output logic                        tx_sdout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err_overflow,
  output logic                        err_underrun,
  output logic                        err_misalign
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } frame_t;

  localparam int unsigned FRAME_W      = $bits(frame_t);
  // Places the sample MSB in slot 1, leaving slot 0 as the one-bit I2S delay
  localparam int unsigned SAMPLE_SHIFT = SLOT_CNT - 1 - DATA_WIDTH;

  logic [CNT_W-1:0]      cnt;
  logic                  frame_end;
  logic [SLOT_W-1:0]     slot;
  logic [DATA_WIDTH-1:0] chan_sample;
  logic [SLOT_CNT-1:0]   slot_word;
  frame_t                frame_q;
  logic [FRAME_W-1:0]    fifo_din;
  logic [FRAME_W-1:0]    fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] left_q;
  logic                  left_pend;
  logic                  push_req;

  assign frame_end   = (cnt == '1);
  assign slot        = cnt[LRCK_BIT-1:SLOT_LSB];
  assign chan_sample = cnt[LRCK_BIT] ? frame_q.right : frame_q.left;
  assign slot_word   = SLOT_CNT'(chan_sample) << SAMPLE_SHIFT;
  assign push_req    = s_axis_valid && s_axis_last && left_pend;
  assign fifo_din    = {left_q, s_axis_data};

  // Free-running timebase and derived I2S clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tx_mclk <= 1'b0;
      tx_sclk <= 1'b0;
      tx_lrck <= 1'b0;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      tx_mclk <= cnt[MCLK_BIT];
      tx_sclk <= cnt[SCLK_BIT];
      tx_lrck <= cnt[LRCK_BIT];
    end
  end

  // Serial data changes only at the start of each bit slot (SCLK falling)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sdout <= 1'b0;
    end else if (cnt[SLOT_LSB-1:0] == '0) begin
      tx_sdout <= slot_word[~slot];
    end
  end

  // Frame register reloads only at the frame boundary; empty FIFO plays silence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q      <= '0;
      err_underrun <= 1'b0;
    end else begin
      err_underrun <= frame_end && fifo_empty;
      if (frame_end) begin
        if (fifo_empty) frame_q <= '0;
        else            frame_q <= frame_t'(fifo_dout);
      end
    end
  end

  // Left/right pairing; every valid beat is consumed, errors are flagged rather than stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q       <= '0;
      left_pend    <= 1'b0;
      err_misalign <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_misalign <= 1'b0;
      err_overflow <= push_req && fifo_full && !frame_end;
      if (s_axis_valid) begin
        if (!s_axis_last) begin
          left_q       <= s_axis_data;
          left_pend    <= 1'b1;
          err_misalign <= left_pend;
        end else begin
          left_pend    <= 1'b0;
          err_misalign <= !left_pend;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (fifo_din),
    .pop   (frame_end),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .ready (s_axis_ready),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Directed bench for axis_i2s_tx with hand-computed serial words and error pulses.
`timescale 1ns/1ps
module tb_axis_i2s_tx;
  import audio_pkg::*;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_last = 1'b0;
  logic          s_axis_ready;
  logic          tx_mclk, tx_sclk, tx_lrck, tx_sdout;
  logic [2:0]    fifo_level;
  logic          err_overflow, err_underrun, err_misalign;

  int n_checks = 0;
  int n_errors = 0;

  axis_i2s_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .tx_mclk      (tx_mclk),
    .tx_sclk      (tx_sclk),
    .tx_lrck      (tx_lrck),
    .tx_sdout     (tx_sdout),
    .fifo_level   (fifo_level),
    .err_overflow (err_overflow),
    .err_underrun (err_underrun),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  // Reference position within the 1024-clk frame, restarted by reset
  int unsigned mcnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 0;
    else        mcnt <= (mcnt + 1) % 1024;
  end

  // Pulse tallies
  int ov_cnt = 0;
  int mis_cnt = 0;
  always @(posedge clk) begin
    ov_cnt  <= ov_cnt + int'(err_overflow);
    mis_cnt <= mis_cnt + int'(err_misalign);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {tx_mclk, tx_sclk, tx_lrck, tx_sdout, s_axis_ready,
            err_overflow, err_underrun, err_misalign, fifo_level};
  endfunction

  function automatic logic [31:0] exp_word(input logic [DW-1:0] v);
    return {1'b0, v, 7'b0};
  endfunction

  task automatic wait_cnt(input int unsigned target);
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (mcnt == target) return;
    end
    n_errors++;
    $display("FAIL wait_cnt timeout: target %0d never reached", target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_axis_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs()), 64'(0));
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    s_axis_data  = d;
    s_axis_last  = last;
    s_axis_valid = 1'b1;
    @(negedge clk);
    s_axis_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send(l, 1'b0);
    send(r, 1'b1);
  endtask

  // Call at frame start (mcnt 0); samples sdout once per slot
  task automatic capture(output logic [31:0] lw, output logic [31:0] rw);
    for (int s = 0; s < 32; s++) begin
      wait_cnt(32'(s) * 16 + 1);
      lw[31-s] = tx_sdout;
    end
    for (int s = 0; s < 32; s++) begin
      wait_cnt(512 + 32'(s) * 16 + 1);
      rw[31-s] = tx_sdout;
    end
  endtask

  task automatic period(input string tag, input bit use_lrck, input int exp);
    logic prev, cur;
    int   t0;
    t0 = -1;
    prev = use_lrck ? tx_lrck : tx_sclk;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cur = use_lrck ? tx_lrck : tx_sclk;
      if (cur && !prev) begin
        if (t0 < 0) t0 = i;
        else begin
          check(tag, 64'(i - t0), 64'(exp));
          return;
        end
      end
      prev = cur;
    end
    n_errors++;
    $display("FAIL %s: no two rising edges seen", tag);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   lw, rw;
    logic [DW-1:0] lv [6];
    logic [DW-1:0] rv [6];
    stereo_frame_t f;
    int            base;

    lv = '{24'hA5A5A5, 24'h123456, 24'h000001, 24'hFFFFFF, 24'h555555, 24'h0F0F0F};
    rv = '{24'h5A5A5A, 24'h654321, 24'h800000, 24'h000000, 24'hAAAAAA, 24'hF0F0F0};

    // 1: single frame, MSB-first with one-bit delay
    do_reset();
    send_frame(24'h800001, 24'h7FFFFE);
    check("t1_level", 64'(fifo_level), 64'd1);
    check("t1_ready", 64'(s_axis_ready), 64'd1);
    wait_cnt(0);
    check("t1_no_underrun", 64'(err_underrun), 64'd0);
    check("t1_level_after_pop", 64'(fifo_level), 64'd0);
    capture(lw, rw);
    check("t1_left_word", 64'(lw), 64'h40000080);
    check("t1_right_word", 64'(rw), 64'h3FFFFF00);

    // 2: idle stream underruns every frame and stays silent
    do_reset();
    wait_cnt(8);
    check("t2_sclk_lo", 64'(tx_sclk), 64'd0);
    wait_cnt(9);
    check("t2_sclk_hi", 64'(tx_sclk), 64'd1);
    check("t2_mclk_lo", 64'(tx_mclk), 64'd0);
    wait_cnt(10);
    check("t2_mclk_hi", 64'(tx_mclk), 64'd1);
    wait_cnt(1023);
    check("t2_underrun_pre", 64'(err_underrun), 64'd0);
    wait_cnt(0);
    check("t2_underrun_1", 64'(err_underrun), 64'd1);
    wait_cnt(1);
    check("t2_underrun_clear", 64'(err_underrun), 64'd0);
    wait_cnt(0);
    check("t2_underrun_2", 64'(err_underrun), 64'd1);
    capture(lw, rw);
    check("t2_silence", 64'({lw, rw}), 64'd0);
    period("t2_sclk_period", 1'b0, 16);
    period("t2_lrck_period", 1'b1, 1024);

    // 3: six frames into a 4-deep FIFO, first four played in order
    do_reset();
    base = ov_cnt;
    for (int i = 0; i < 6; i++) send_frame(lv[i], rv[i]);
    repeat (2) @(negedge clk);
    check("t3_overflows", 64'(ov_cnt - base), 64'd2);
    check("t3_level_full", 64'(fifo_level), 64'd4);
    check("t3_ready_low", 64'(s_axis_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wait_cnt(0);
      if (i == 0) begin
        check("t3_level_after_pop", 64'(fifo_level), 64'd3);
        check("t3_ready_back", 64'(s_axis_ready), 64'd1);
      end
      capture(lw, rw);
      check($sformatf("t3_frame%0d_left", i), 64'(lw), 64'(exp_word(lv[i])));
      check($sformatf("t3_frame%0d_right", i), 64'(rw), 64'(exp_word(rv[i])));
    end
    wait_cnt(0);
    check("t3_drained_underrun", 64'(err_underrun), 64'd1);

    // 4: L,L,R keeps second L; lone R is dropped
    do_reset();
    base = mis_cnt;
    send(24'h111111, 1'b0);
    send(24'h222222, 1'b0);
    send(24'h333333, 1'b1);
    repeat (2) @(negedge clk);
    check("t4_misalign_llr", 64'(mis_cnt - base), 64'd1);
    check("t4_level", 64'(fifo_level), 64'd1);
    send(24'h444444, 1'b1);
    repeat (2) @(negedge clk);
    check("t4_misalign_r", 64'(mis_cnt - base), 64'd2);
    check("t4_level_unchanged", 64'(fifo_level), 64'd1);
    wait_cnt(0);
    capture(lw, rw);
    check("t4_left_word", 64'(lw), 64'(exp_word(24'h222222)));
    check("t4_right_word", 64'(rw), 64'(exp_word(24'h333333)));

    // 5a: push on the pop cycle into a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(lv[i], rv[i]);
    base = ov_cnt;
    wait_cnt(1022);
    send(24'h0A0A0A, 1'b0);
    send(24'h0B0B0B, 1'b1);
    check("t5_no_overflow", 64'(err_overflow), 64'd0);
    check("t5_level_stays", 64'(fifo_level), 64'd4);
    repeat (2) @(negedge clk);
    check("t5_overflow_count", 64'(ov_cnt - base), 64'd0);

    // 5b: push on the pop cycle into an empty FIFO plays next frame
    do_reset();
    wait_cnt(1022);
    send(24'hC0FFEE, 1'b0);
    send(24'h00BEEF, 1'b1);
    check("t5b_underrun", 64'(err_underrun), 64'd1);
    check("t5b_level", 64'(fifo_level), 64'd1);
    wait_cnt(0);
    check("t5b_no_underrun", 64'(err_underrun), 64'd0);
    capture(lw, rw);
    check("t5b_left_word", 64'(lw), 64'(exp_word(24'hC0FFEE)));
    check("t5b_right_word", 64'(rw), 64'(exp_word(24'h00BEEF)));

    // 6: asynchronous reset mid right channel
    do_reset();
    f.left  = 24'h0000FF;
    f.right = 24'hFFFFFF;
    send_frame(f.left, f.right);
    send_frame(24'h123123, 24'h321321);
    wait_cnt(0);
    wait_cnt(700);
    check("t6_lrck_right", 64'(tx_lrck), 64'd1);
    check("t6_sdout_pre", 64'(tx_sdout), 64'd1);
    check("t6_level_pre", 64'(fifo_level), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_outputs", 64'(outs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(8);
    check("t6_sclk_restart_lo", 64'(tx_sclk), 64'd0);
    wait_cnt(9);
    check("t6_sclk_restart_hi", 64'(tx_sclk), 64'd1);
    check("t6_level_lost", 64'(fifo_level), 64'd0);
    wait_cnt(0);
    check("t6_first_load_underrun", 64'(err_underrun), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
